// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector: registered Moore match flag one cycle after the last pattern bit.
// No backpressure: x is consumed on every x_valid edge, and a cfg_load edge drops that edge's bit.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b101),
  parameter int                 DEF_LEN     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   active_len
);

  localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_C = (DEF_LEN <= 1)       ? LEN_W'(1) :
                                           (DEF_LEN > MAX_LEN)  ? MAX_L     : LEN_W'(DEF_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               y_q, y_d;

  logic [MAX_LEN-1:0] shift_hist;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l < LEN_W'(2)) return LEN_W'(1);
    else if (l > MAX_L) return MAX_L;
    else return l;
  endfunction

  always_comb begin
    hist_d     = hist_q;
    pat_d      = pat_q;
    fill_d     = fill_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(len_q));
    shift_hist = {hist_q[MAX_LEN-2:0], x};
    fill_inc   = (fill_q == MAX_L) ? fill_q : fill_q + LEN_W'(1);
    // Compare only the low active_len bits of the post-shift history.
    match      = x_valid && !cfg_load && (fill_inc >= len_q) &&
                 ((shift_hist & len_mask) == (pat_q & len_mask));

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = clamp_len(cfg_len);
      fill_d = '0;
      y_d    = 1'b0;
    end else if (x_valid) begin
      hist_d = shift_hist;
      fill_d = (match && !overlap) ? '0 : fill_inc;
      y_d    = match;
    end

    if (cnt_clr)                     cnt_d = '0;
    else if (match && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      pat_q  <= DEF_PATTERN;
      fill_q <= '0;
      len_q  <= DEF_LEN_C;
      cnt_q  <= '0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      fill_q <= fill_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
    end
  end

  assign y           = y_q;
  assign match_count = cnt_q;
  assign active_len  = len_q;

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
- REQ-001: Parameter MAX_LEN, default 8, maximum pattern length in bits (2..16).
- REQ-002: Parameter LEN_W, default 4, width of length fields; SHALL satisfy 2^LEN_W > MAX_LEN.
- REQ-003: Parameter CNT_W, default 8, width of the match counter.
- REQ-004: Parameter DEF_PATTERN, default 'b101 (MAX_LEN bits), pattern loaded at reset.
- REQ-005: Parameter DEF_LEN, default 3, pattern length loaded at reset.
- REQ-006: clk  input  1  single clock; all state updates on its rising edge.
- REQ-007: reset  input  1  asynchronous, active-high reset.
- REQ-008: x  input  1  serial data bit.
- REQ-009: x_valid  input  1  x sampled only when high.
- REQ-010: overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- REQ-011: cfg_load  input  1  one-cycle strobe loading cfg_pattern and cfg_len.
- REQ-012: cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is first-received, bit [0] last-received.
- REQ-013: cfg_len  input  LEN_W  requested pattern length.
- REQ-014: cnt_clr  input  1  synchronous clear of match_count.
- REQ-015: y  output  1  Moore match flag, registered.
- REQ-016: match_count  output  CNT_W  saturating count of match events.
- REQ-017: active_len  output  LEN_W  currently effective pattern length.

Function
- REQ-018: Block SHALL hold a MAX_LEN-bit history register, a fill counter (0..MAX_LEN, saturating), the active pattern, and the active length.
- REQ-019: On a rising edge with x_valid=1 and cfg_load=0: history shifts left with x entering bit 0; fill increments, saturating at MAX_LEN.
- REQ-020: A match event occurs on that edge when the updated fill >= active_len and updated history[active_len-1:0] == pattern[active_len-1:0].
- REQ-021: y SHALL be 1 in the cycle after an edge producing a match event and 0 after any edge with x_valid=1 and no match; Moore output, no combinational path from x to y.
- REQ-022: With x_valid=0, history, fill and y SHALL hold their values.
- REQ-023: overlap=1: fill unaffected by a match; a pattern suffix may start the next match.
- REQ-024: overlap=0: on a match event fill SHALL become 0, so the next match requires active_len fresh bits.
- REQ-025: overlap is sampled per edge; changing it mid-stream affects only subsequent match events.
- REQ-026: cfg_load=1: pattern <= cfg_pattern, active_len <= clamp(cfg_len), fill <= 0, y <= 0; x on that edge is discarded, regardless of x_valid.
- REQ-027: clamp: cfg_len=0 or 1 becomes 1; cfg_len > MAX_LEN becomes MAX_LEN.
- REQ-028: match_count increments by 1 per match event, saturating at 2^CNT_W-1 (no wrap).
- REQ-029: cnt_clr=1 sets match_count to 0; simultaneous match event is not counted (clear wins); y unaffected by cnt_clr.
- REQ-030: Detection latency: y rises exactly one cycle after the edge sampling the final pattern bit.

Reset
- REQ-031: reset=1 SHALL immediately, without a clock edge, set y=0, match_count=0, history=0, fill=0, pattern=DEF_PATTERN, active_len=clamp(DEF_LEN).
- REQ-032: While reset=1 all inputs are ignored; operation resumes on the first rising edge after reset deasserts.
- REQ-033: Reset asserted mid-pattern SHALL discard all partial history; no match may complete using bits sampled before reset.

Verification
- REQ-034: Defaults, overlap=1, x_valid=1, stream 1,0,1,0,1 -> y high after bits 3 and 5 only; match_count=2.
- REQ-035: Defaults, overlap=0, stream 1,0,1,0,1,0,1 -> y high after bits 3 and 7 only; match_count=2.
- REQ-036: cfg_load pattern 'b1101, len 4, overlap=1, stream 1,1,0,1,1,0,1 -> y high after bits 4 and 7; active_len=4; match_count=2.
- REQ-037: Defaults, stream 1,0,1 with x_valid low for 3 cycles between each bit and after -> y rises one cycle after bit 3 and stays 1 while x_valid=0; match_count=1.
- REQ-038: CNT_W=4, overlap=1, 20 repetitions of 1,0 after initial 1 -> match_count saturates at 15; cnt_clr on a match edge -> match_count=0.
- REQ-039: Stream 1,0, then async reset pulse between edges, then 1 -> y=0 and match_count=0 immediately on reset; no match after the final 1; cfg_len=0 load -> active_len=1.
